// File: rtl/costas_acq_ctrl.sv
// Acquisition / lock sequencer for the costas BPSK loop: windowed sum(|I|-|Q|) metric driving gain, sweep and lock decisions.
// States: IDLE 0 | CLEAR 1 (loop_clr pulse) | ACQ 2 | TRACK 3 | LOCK 4 | SWEEP 5 (one-cycle frequency step).
module costas_acq_ctrl #(
  parameter int          WIN_LOG2    = 8,
  parameter int          LOCK_THR    = 1000000,
  parameter int          LOSS_THR    = 200000,
  parameter int          ACQ_WINS    = 4,
  parameter int          TRK_WINS    = 8,
  parameter int          LOSS_WINS   = 3,
  parameter int          ACQ_TIMEOUT = 64,
  parameter logic [31:0] FREQ_CENTER = 32'h051EB852,
  parameter logic [31:0] SWEEP_STEP  = 32'h00020000,
  parameter int          SWEEP_MAX   = 4,
  parameter logic [3:0]  ACQ_KP      = 4'd4,
  parameter logic [3:0]  ACQ_KI      = 4'd8,
  parameter logic [3:0]  TRK_KP      = 4'd7,
  parameter logic [3:0]  TRK_KI      = 4'd12
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       enable,
  input  logic                       sample_valid,
  input  logic signed [15:0]         I_in,
  input  logic signed [15:0]         Q_in,
  output logic [31:0]                freq_word,
  output logic                       loop_clr,
  output logic [3:0]                 kp_shift,
  output logic [3:0]                 ki_shift,
  output logic                       locked,
  output logic [2:0]                 state_out,
  output logic signed [WIN_LOG2+16:0] lock_metric
);

  localparam int          MW          = WIN_LOG2 + 17;
  localparam logic [7:0]  ACQ_WINS_C  = 8'(ACQ_WINS);
  localparam logic [7:0]  TRK_WINS_C  = 8'(TRK_WINS);
  localparam logic [7:0]  LOSS_WINS_C = 8'(LOSS_WINS);
  localparam logic [7:0]  K_MAX_C     = 8'(2 * SWEEP_MAX);
  localparam logic [15:0] TIMEOUT_C   = 16'(ACQ_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACQ   = 3'd2,
    S_TRACK = 3'd3,
    S_LOCK  = 3'd4,
    S_SWEEP = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          freq_q, freq_d;
  logic                 clr_q, clr_d;
  logic                 locked_q, locked_d;
  logic [3:0]           kp_q, kp_d, ki_q, ki_d;
  logic signed [MW-1:0] acc_q, acc_d, metric_q, metric_d;
  logic [WIN_LOG2-1:0]  cnt_q, cnt_d;
  logic                 win_q, win_d;
  logic [7:0]           good_q, good_d, bad_q, bad_d, k_q, k_d;
  logic [15:0]          to_q, to_d;

  logic [15:0]          abs_i, abs_q;
  logic signed [16:0]   term;
  logic signed [MW-1:0] acc_sum;
  logic signed [31:0]   metric_ext;
  logic                 good_win, bad_win, active;
  logic [7:0]           good_inc, bad_inc, k_next, sweep_mag;
  logic [15:0]          to_inc;
  logic [31:0]          sweep_off, sweep_freq;

  // -32768 has no positive counterpart in 16 bits, so it saturates.
  function automatic logic [15:0] sat_abs(input logic signed [15:0] x);
    if (x == 16'sh8000) return 16'h7fff;
    if (x[15]) return 16'(-x);
    return 16'(x);
  endfunction

  assign abs_i      = sat_abs(I_in);
  assign abs_q      = sat_abs(Q_in);
  assign term       = $signed({1'b0, abs_i}) - $signed({1'b0, abs_q});
  assign acc_sum    = acc_q + {{(MW-17){term[16]}}, term};
  assign metric_ext = {{(32-MW){metric_q[MW-1]}}, metric_q};
  assign good_win   = metric_ext > LOCK_THR;
  assign bad_win    = metric_ext < LOSS_THR;
  assign active     = (state_q == S_ACQ) || (state_q == S_TRACK) || (state_q == S_LOCK);

  assign good_inc   = good_q + 8'd1;
  assign bad_inc    = bad_q + 8'd1;
  assign to_inc     = to_q + 16'd1;
  assign k_next     = (k_q == K_MAX_C) ? 8'd0 : k_q + 8'd1;
  // Odd k steps up, even k steps down; both use magnitude ceil(k/2).
  assign sweep_mag  = (k_next + 8'd1) >> 1;
  assign sweep_off  = 32'(sweep_mag) * SWEEP_STEP;
  assign sweep_freq = k_next[0] ? FREQ_CENTER + sweep_off : FREQ_CENTER - sweep_off;

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    metric_d = metric_q;
    win_d    = 1'b0;
    if (active) begin
      if (sample_valid) begin
        if (&cnt_q) begin
          metric_d = acc_sum;
          acc_d    = '0;
          cnt_d    = '0;
          win_d    = 1'b1;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_q + WIN_LOG2'(1);
        end
      end
    end else begin
      acc_d = '0;
      cnt_d = '0;
    end
    if (!enable || state_q == S_IDLE) metric_d = '0;
  end

  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    clr_d    = 1'b0;
    locked_d = locked_q;
    kp_d     = kp_q;
    ki_d     = ki_q;
    good_d   = good_q;
    bad_d    = bad_q;
    to_d     = to_q;
    k_d      = k_q;
    if (!enable) begin
      state_d  = S_IDLE;
      locked_d = 1'b0;
      kp_d     = ACQ_KP;
      ki_d     = ACQ_KI;
      good_d   = '0;
      bad_d    = '0;
      to_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CLEAR;
          clr_d   = 1'b1;
          k_d     = '0;
          freq_d  = FREQ_CENTER;
        end
        S_CLEAR: begin
          state_d = S_ACQ;
          good_d  = '0;
          bad_d   = '0;
          to_d    = '0;
        end
        S_ACQ: if (win_q) begin
          good_d = good_win ? good_inc : 8'd0;
          to_d   = to_inc;
          if (good_win && good_inc == ACQ_WINS_C) begin
            state_d = S_TRACK;
            good_d  = '0;
            to_d    = '0;
            kp_d    = TRK_KP;
            ki_d    = TRK_KI;
          end else if (to_inc == TIMEOUT_C) begin
            state_d = S_SWEEP;
            to_d    = '0;
          end
        end
        S_SWEEP: begin
          state_d = S_CLEAR;
          clr_d   = 1'b1;
          k_d     = k_next;
          freq_d  = sweep_freq;
        end
        S_TRACK: if (win_q) begin
          if (good_win) begin
            good_d = good_inc;
            if (good_inc == TRK_WINS_C) begin
              state_d  = S_LOCK;
              locked_d = 1'b1;
              good_d   = '0;
            end
          end else if (bad_win) begin
            // Fall back to wide gains without disturbing the loop.
            state_d = S_ACQ;
            good_d  = '0;
            bad_d   = '0;
            to_d    = '0;
            kp_d    = ACQ_KP;
            ki_d    = ACQ_KI;
          end else begin
            good_d = '0;
          end
        end
        S_LOCK: if (win_q) begin
          if (bad_win) begin
            bad_d = bad_inc;
            if (bad_inc == LOSS_WINS_C) begin
              state_d  = S_CLEAR;
              clr_d    = 1'b1;
              locked_d = 1'b0;
              bad_d    = '0;
              kp_d     = ACQ_KP;
              ki_d     = ACQ_KI;
            end
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      freq_q   <= FREQ_CENTER;
      clr_q    <= 1'b0;
      locked_q <= 1'b0;
      kp_q     <= ACQ_KP;
      ki_q     <= ACQ_KI;
      acc_q    <= '0;
      metric_q <= '0;
      cnt_q    <= '0;
      win_q    <= 1'b0;
      good_q   <= '0;
      bad_q    <= '0;
      to_q     <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      freq_q   <= freq_d;
      clr_q    <= clr_d;
      locked_q <= locked_d;
      kp_q     <= kp_d;
      ki_q     <= ki_d;
      acc_q    <= acc_d;
      metric_q <= metric_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      to_q     <= to_d;
      k_q      <= k_d;
    end
  end

  assign freq_word   = freq_q;
  assign loop_clr    = clr_q;
  assign kp_shift    = kp_q;
  assign ki_shift    = ki_q;
  assign locked      = locked_q;
  assign state_out   = state_q;
  assign lock_metric = metric_q;

endmodule

// File: tb/tb_costas_acq_ctrl.sv
// Randomized bench for costas_acq_ctrl against a window-level reference model of the sequencer.
module tb_costas_acq_ctrl;

  localparam int          WIN_LEN  = 16;
  localparam int          LOCK_T   = 100000;
  localparam int          LOSS_T   = 20000;
  localparam int          TIMEOUT  = 6;
  localparam logic [31:0] CENTER   = 32'h051EB852;
  localparam int          STEP     = 131072;

  logic               sys_clk, sys_rst_n, enable, sample_valid;
  logic signed [15:0] I_in, Q_in;
  logic [31:0]        freq_word;
  logic               loop_clr, locked;
  logic [3:0]         kp_shift, ki_shift;
  logic [2:0]         state_out;
  logic signed [20:0] lock_metric;

  costas_acq_ctrl #(
    .WIN_LOG2(4), .LOCK_THR(LOCK_T), .LOSS_THR(LOSS_T), .ACQ_TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
    .sample_valid(sample_valid), .I_in(I_in), .Q_in(Q_in),
    .freq_word(freq_word), .loop_clr(loop_clr), .kp_shift(kp_shift),
    .ki_shift(ki_shift), .locked(locked), .state_out(state_out),
    .lock_metric(lock_metric)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: window metric as a plain sum over stored samples,
  // sweep frequency from a table of step multiples.
  int          m_state, m_kp, m_ki, m_metric, m_good, m_bad, m_to, m_k;
  logic [31:0] m_freq;
  bit          m_clr, m_locked, m_pend;
  int          m_win[$];
  int          offs[0:8];

  function automatic int sabs(input int x);
    if (x == -32768) return 32767;
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    m_state = 0; m_freq = CENTER; m_clr = 0; m_locked = 0;
    m_kp = 4; m_ki = 8; m_metric = 0; m_pend = 0;
    m_good = 0; m_bad = 0; m_to = 0; m_k = 0;
    m_win.delete();
  endtask

  task automatic model_edge(input bit en, input bit sv, input int i, input int q);
    bit pend_now, good, bad, act;
    int s;
    pend_now = m_pend;
    good = m_metric > LOCK_T;
    bad  = m_metric < LOSS_T;
    act  = (m_state == 2) || (m_state == 3) || (m_state == 4);
    m_pend = 0;
    if (act) begin
      if (sv) begin
        m_win.push_back(sabs(i) - sabs(q));
        if (m_win.size() == WIN_LEN) begin
          s = 0;
          foreach (m_win[j]) s += m_win[j];
          m_metric = s;
          m_win.delete();
          m_pend = 1;
        end
      end
    end else m_win.delete();
    if (!en || m_state == 0) m_metric = 0;
    m_clr = 0;
    if (!en) begin
      m_state = 0; m_locked = 0; m_kp = 4; m_ki = 8;
      m_good = 0; m_bad = 0; m_to = 0;
    end else begin
      case (m_state)
        0: begin m_state = 1; m_clr = 1; m_k = 0; m_freq = CENTER; end
        1: begin m_state = 2; m_good = 0; m_bad = 0; m_to = 0; end
        2: if (pend_now) begin
          m_good = good ? m_good + 1 : 0;
          m_to++;
          if (m_good == 4) begin m_state = 3; m_good = 0; m_kp = 7; m_ki = 12; end
          else if (m_to == TIMEOUT) m_state = 5;
        end
        5: begin
          m_k = (m_k + 1) % 9;
          m_freq = CENTER + 32'(offs[m_k] * STEP);
          m_state = 1; m_clr = 1;
        end
        3: if (pend_now) begin
          if (good) begin
            m_good++;
            if (m_good == 8) begin m_state = 4; m_locked = 1; m_good = 0; end
          end else if (bad) begin
            m_state = 2; m_good = 0; m_bad = 0; m_to = 0; m_kp = 4; m_ki = 8;
          end else m_good = 0;
        end
        4: if (pend_now) begin
          if (bad) begin
            m_bad++;
            if (m_bad == 3) begin
              m_state = 1; m_clr = 1; m_locked = 0; m_bad = 0; m_kp = 4; m_ki = 8;
            end
          end else m_bad = 0;
        end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic check_all();
    check_val("state", 32'(state_out), m_state);
    check_val("freq", freq_word, m_freq);
    check_val("loop_clr", 32'(loop_clr), 32'(m_clr));
    check_val("kp", 32'(kp_shift), m_kp);
    check_val("ki", 32'(ki_shift), m_ki);
    check_val("locked", 32'(locked), 32'(m_locked));
    check_val("metric", 32'(lock_metric), m_metric);
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    if (sys_rst_n) model_edge(enable, sample_valid, int'(I_in), int'(Q_in));
    #1;
    check_all();
  endtask

  // 0 good, 1 bad, 2 neutral, 3 saturating -32768
  task automatic drive(input int rg);
    int i, q;
    case (rg)
      0: begin i = int'($urandom_range(9000, 32767)); q = int'($urandom_range(0, 2000)); end
      1: begin i = int'($urandom_range(0, 2000)); q = int'($urandom_range(9000, 32767)); end
      2: begin i = int'($urandom_range(3000, 5000)); q = 0; end
      default: begin i = -32768; q = 0; end
    endcase
    if (rg < 3) begin
      if ($urandom_range(0, 1) == 1) i = -i;
      if ($urandom_range(0, 1) == 1) q = -q;
    end
    I_in = 16'(i);
    Q_in = 16'(q);
    sample_valid = (rg == 3) ? 1'b1 : ($urandom_range(0, 4) != 0);
  endtask

  task automatic run(input int rg, input int n);
    for (int c = 0; c < n; c++) begin
      drive(rg);
      cycle();
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    #2;
    model_reset();
    check_val("rst_state", 32'(state_out), 0);
    check_val("rst_freq", freq_word, CENTER);
    check_val("rst_locked", 32'(locked), 0);
    check_val("rst_kp", 32'(kp_shift), 4);
    check_val("rst_ki", 32'(ki_shift), 8);
    check_all();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  logic [31:0] sweep_exp[0:9];
  int clr_cnt, idx, aborts_trk, aborts_clr, rg;

  initial begin
    offs[0] = 0;
    for (int j = 1; j <= 4; j++) begin
      offs[2*j-1] = j;
      offs[2*j]   = -j;
    end
    for (int j = 0; j < 10; j++) begin
      if (j == 0 || j == 9) sweep_exp[j] = CENTER;
      else if (j % 2 == 1) sweep_exp[j] = CENTER + 32'(((j + 1) / 2) * STEP);
      else sweep_exp[j] = CENTER - 32'((j / 2) * STEP);
    end

    enable = 1'b0; sample_valid = 1'b0; I_in = '0; Q_in = '0;
    sys_rst_n = 1'b0;
    #12;
    do_reset();

    // acquisition to lock
    enable = 1'b1;
    clr_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      drive(0);
      cycle();
      if (loop_clr) clr_cnt++;
    end
    check_val("acq_clr_pulses", clr_cnt, 1);
    check_val("lock_state", 32'(state_out), 4);
    check_val("lock_flag", 32'(locked), 1);
    check_val("lock_kp", 32'(kp_shift), 7);
    check_val("lock_ki", 32'(ki_shift), 12);

    // loss of lock with an intervening neutral window
    run(1, 40);
    run(2, 25);
    run(1, 120);
    run(0, 450);

    // asynchronous reset mid-run, then sweep
    do_reset();
    idx = 0;
    for (int c = 0; c < 3000 && idx < 10; c++) begin
      drive(1);
      cycle();
      if (loop_clr) begin
        check_val("sweep_freq", freq_word, sweep_exp[idx]);
        idx++;
      end
    end
    check_val("sweep_steps", idx, 10);

    // saturation: one window of 16 x (-32768, 0)
    do_reset();
    run(3, 19);
    check_val("sat_metric", 32'(lock_metric), 32'd524272);

    // random mix with aborts in TRACK and CLEAR
    aborts_trk = 0;
    aborts_clr = 0;
    for (int p = 0; p < 25; p++) begin
      if (p == 12) do_reset();
      rg = int'($urandom_range(0, 2));
      for (int c = int'($urandom_range(30, 300)); c > 0; c--) begin
        drive(rg);
        enable = 1'b1;
        if ((m_state == 3 && aborts_trk < 3 && $urandom_range(0, 40) == 0) ||
            (m_state == 1 && aborts_clr < 3 && $urandom_range(0, 2) == 0)) begin
          if (m_state == 3) aborts_trk++; else aborts_clr++;
          enable = 1'b0;
          cycle();
          check_val("abort_idle", 32'(state_out), 0);
          check_val("abort_clr", 32'(loop_clr), 0);
          check_val("abort_locked", 32'(locked), 0);
          enable = 1'b1;
        end else if ($urandom_range(0, 299) == 0) begin
          enable = 1'b0;
          cycle();
          enable = 1'b1;
        end else begin
          cycle();
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
